// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared types and constants for the bit-serial arithmetic controller
package arith_pkg;

  typedef logic [2:0] opsel_t;

  localparam opsel_t OPS_ADD = 3'b000;
  localparam opsel_t OPS_SUB = 3'b001;
  localparam opsel_t OPS_INC = 3'b010;
  localparam opsel_t OPS_DEC = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/shift_reg_rsh.sv
// rtl/shift_reg_rsh.sv - parallel-load right-shift register, MSB fill from shift_in
module shift_reg_rsh #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             shift_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Load wins over shift so a new operand never mixes with a shifting one.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_val;
    end else if (shift) begin
      data_d = {shift_in, data_q[WIDTH-1:1]};
    end
  end

  // Register update with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/arith_serial_ctrl.sv
// rtl/arith_serial_ctrl.sv - sequences WIDTH-bit operands LSB-first through a 1-bit arithmetic slice
module arith_serial_ctrl
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  opsel_t           opsel_in,
  input  logic             cin_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             op1,
  output logic             op2,
  output logic             Cin_final,
  output opsel_t           opsel,
  input  logic             arith_result,
  input  logic             arith_Cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  ctrl_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d;
  opsel_t op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic cout_q, cout_d;
  logic msb_cin_q, msb_cin_d;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;

  logic running;
  logic last_bit;
  logic accept;

  assign running  = (state_q == RUN);
  assign last_bit = running && (cnt_q == LAST_BIT);
  assign accept   = start && !running;

  // Only bit 0 of the operand shifters and the upper bits of the result shifter feed logic.
  logic unused_sh_bits;
  assign unused_sh_bits = ^{a_sh[WIDTH-1:1], b_sh[WIDTH-1:1], res_sh[0]};

  shift_reg_rsh #(.WIDTH(WIDTH)) u_a_sh (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (a),
    .shift    (running),
    .shift_in (1'b0),
    .q        (a_sh)
  );

  shift_reg_rsh #(.WIDTH(WIDTH)) u_b_sh (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (b),
    .shift    (running),
    .shift_in (1'b0),
    .q        (b_sh)
  );

  shift_reg_rsh #(.WIDTH(WIDTH)) u_res_sh (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val ('0),
    .shift    (running),
    .shift_in (arith_result),
    .q        (res_sh)
  );

  // Next-state, operand capture, carry feedback and end-of-operation result latching.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    op_d      = op_q;
    result_d  = result_q;
    cout_d    = cout_q;
    msb_cin_d = msb_cin_q;

    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      op_d    = opsel_in;
      carry_d = cin_in;
      cnt_d   = '0;
    end

    if (running) begin
      carry_d = arith_Cout;
      cnt_d   = cnt_q + CW'(1);
      if (last_bit) begin
        // The final sum bit lands in the result in the same edge the shifter would take it.
        result_d  = {arith_result, res_sh[WIDTH-1:1]};
        cout_d    = arith_Cout;
        msb_cin_d = carry_q;
      end
    end
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      op_q      <= '0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      msb_cin_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      op_q      <= op_d;
      result_q  <= result_d;
      cout_q    <= cout_d;
      msb_cin_q <= msb_cin_d;
    end
  end

  assign ready     = !running;
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = msb_cin_q ^ cout_q;
  assign op1       = running ? a_sh[0] : 1'b0;
  assign op2       = running ? b_sh[0] : 1'b0;
  assign Cin_final = running ? carry_q : 1'b0;
  assign opsel     = op_q;

endmodule

// File: tb/tb_arith_serial_ctrl.sv
// tb/tb_arith_serial_ctrl.sv - randomized and directed bench with a word-level reference model
module tb_arith_serial_ctrl;
  import arith_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  opsel_t       opsel_in;
  logic         cin_in;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         op1;
  logic         op2;
  logic         Cin_final;
  opsel_t       opsel;
  logic         arith_result;
  logic         arith_Cout;

  int  n_checks = 0;
  int  n_fail   = 0;
  time t_done   = 0;

  arith_serial_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .opsel_in     (opsel_in),
    .cin_in       (cin_in),
    .a            (a),
    .b            (b),
    .ready        (ready),
    .done         (done),
    .result       (result),
    .cout         (cout),
    .ovf          (ovf),
    .op1          (op1),
    .op2          (op2),
    .Cin_final    (Cin_final),
    .opsel        (opsel),
    .arith_result (arith_result),
    .arith_Cout   (arith_Cout)
  );

  always #5 clk = ~clk;

  // 1-bit slice: op1 + f(op2, opsel) + Cin
  logic       f_b;
  logic [1:0] slice_sum;
  always_comb begin
    case (opsel)
      OPS_ADD: f_b = op2;
      OPS_SUB: f_b = ~op2;
      OPS_INC: f_b = 1'b0;
      OPS_DEC: f_b = 1'b1;
      default: f_b = op2;
    endcase
    slice_sum    = {1'b0, op1} + {1'b0, f_b} + {1'b0, Cin_final};
    arith_result = slice_sum[0];
    arith_Cout   = slice_sum[1];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word-level reference: returns {ovf, cout, result}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input opsel_t op, input logic ci);
    logic [W-1:0] yy;
    logic [W:0]   full;
    logic [W-1:0] low;
    case (op)
      OPS_ADD: yy = y;
      OPS_SUB: yy = ~y;
      OPS_INC: yy = '0;
      OPS_DEC: yy = '1;
      default: yy = y;
    endcase
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, ci};
    low  = {1'b0, x[W-2:0]} + {1'b0, yy[W-2:0]} + {{(W-1){1'b0}}, ci};
    return {low[W-1] ^ full[W], full[W], full[W-1:0]};
  endfunction

  task automatic chk_reset(input string tag);
    check({tag, "_ready"},  {31'd0, ready}, 32'd1);
    check({tag, "_done"},   {31'd0, done}, 32'd0);
    check({tag, "_result"}, {24'd0, result}, 32'd0);
    check({tag, "_cout"},   {31'd0, cout}, 32'd0);
    check({tag, "_ovf"},    {31'd0, ovf}, 32'd0);
    check({tag, "_opsel"},  {29'd0, opsel}, 32'd0);
    check({tag, "_slice"},  {29'd0, op1, op2, Cin_final}, 32'd0);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge where done is visible.
  task automatic do_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input opsel_t xop, input logic xc, input bit pulse_mid,
                       input logic [W-1:0] er, input logic ec, input logic eo);
    int           lat;
    bit           got_done;
    bit           busy_ok;
    logic [W-1:0] sa;
    logic [W-1:0] sb;
    a = xa; b = xb; opsel_in = xop; cin_in = xc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    opsel_in = opsel_t'($urandom); cin_in = 1'($urandom);
    lat = 1; got_done = 0; busy_ok = 1; sa = '0; sb = '0;
    while (lat <= 20) begin
      if (done) begin
        got_done = 1;
        break;
      end
      if (lat <= W) begin
        sa[lat-1] = op1;
        sb[lat-1] = op2;
        if (ready) busy_ok = 0;
      end
      start = (pulse_mid && lat == 4) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, {31'd0, got_done}, 32'd1);
    if (got_done) begin
      t_done = $time;
      check({tag, "_latency"}, lat, 32'd9);
      check({tag, "_busy"},    {31'd0, busy_ok}, 32'd1);
      check({tag, "_op1"},     {24'd0, sa}, {24'd0, xa});
      check({tag, "_op2"},     {24'd0, sb}, {24'd0, xb});
      check({tag, "_result"},  {24'd0, result}, {24'd0, er});
      check({tag, "_cout"},    {31'd0, cout}, {31'd0, ec});
      check({tag, "_ovf"},     {31'd0, ovf}, {31'd0, eo});
      check({tag, "_opsel"},   {29'd0, opsel}, {29'd0, xop});
      check({tag, "_ready"},   {31'd0, ready}, 32'd1);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_ready", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    logic [W+1:0] m;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    opsel_t       rop;
    logic         rc;
    time          t1;
    bit           seen;
    opsel_t       op_list [4];

    op_list[0] = OPS_ADD; op_list[1] = OPS_SUB; op_list[2] = OPS_INC; op_list[3] = OPS_DEC;
    rst = 1'b1; start = 1'b0; opsel_in = '0; cin_in = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;
    idle_cycle();

    do_op("add",  8'h3C, 8'h05, OPS_ADD, 1'b0, 0, 8'h41, 1'b0, 1'b0);
    idle_cycle();
    do_op("sub1", 8'h05, 8'h07, OPS_SUB, 1'b1, 0, 8'hFE, 1'b0, 1'b0);
    idle_cycle();
    do_op("sub2", 8'h80, 8'h01, OPS_SUB, 1'b1, 0, 8'h7F, 1'b1, 1'b1);
    idle_cycle();
    do_op("inc",  8'hFF, 8'h00, OPS_INC, 1'b1, 0, 8'h00, 1'b1, 1'b0);
    idle_cycle();
    do_op("dec",  8'h00, 8'h00, OPS_DEC, 1'b0, 0, 8'hFF, 1'b0, 1'b0);

    // Back-to-back: next start issued in the DONE cycle.
    do_op("b2b1", 8'h3C, 8'h05, OPS_ADD, 1'b0, 0, 8'h41, 1'b0, 1'b0);
    t1 = t_done;
    do_op("b2b2", 8'h80, 8'h01, OPS_SUB, 1'b1, 0, 8'h7F, 1'b1, 1'b1);
    check("b2b_spacing", int'((t_done - t1) / 10), 32'd9);
    idle_cycle();

    // start pulsed mid-operation must be ignored.
    do_op("pulse", 8'h3C, 8'h05, OPS_ADD, 1'b0, 1, 8'h41, 1'b0, 1'b0);
    idle_cycle();

    // Reset during bit 3 of an ADD aborts with no done.
    a = 8'h3C; b = 8'h05; opsel_in = OPS_ADD; cin_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("abort_busy", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset("abort");
    seen = 0;
    repeat (12) begin
      if (done) seen = 1;
      @(posedge clk); #1;
    end
    check("abort_no_done", {31'd0, seen}, 32'd0);

    // rst and start together: start dropped.
    a = 8'h12; b = 8'h34; opsel_in = OPS_DEC; cin_in = 1'b1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk_reset("rst_start");
    @(posedge clk); #1;
    check("rst_start_idle", {31'd0, ready}, 32'd1);

    for (int i = 0; i < 40; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rop = op_list[$urandom_range(0, 3)];
      rc  = 1'($urandom);
      m   = model(ra, rb, rop, rc);
      do_op("rand", ra, rb, rop, rc, bit'($urandom_range(0, 1)), m[W-1:0], m[W], m[W+1]);
      if ($urandom_range(0, 2) != 0) idle_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
